// File: rtl/fifo_rptr_empty.sv
// Read-side pointer/empty controller for a dual-clock FIFO (rclk domain only).
// Define FIFO_RLEVEL_EN to add the registered reader-side occupancy output rlevel.
module fifo_rptr_empty #(
  parameter int ADRRSIZE    = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADRRSIZE:0]   wptr,
  output logic [ADRRSIZE-1:0] raddr,
  output logic [ADRRSIZE:0]   rptr,
  output logic                rempty
`ifdef FIFO_RLEVEL_EN
  ,
  output logic [ADRRSIZE:0]   rlevel
`endif
);

  logic [ADRRSIZE:0] rbin_reg;
  logic [ADRRSIZE:0] rptr_reg;
  logic              rempty_reg;
  logic [ADRRSIZE:0] rbin_next;
  logic [ADRRSIZE:0] rgray_next;
  logic [ADRRSIZE:0] rq_wptr;
  logic              pop;

  // Plain flop chain: no logic between stages so each stage sees a clean Gray value.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : gen_sync
    logic [ADRRSIZE:0] stage_reg;
    if (gi == 0) begin : gen_first
      always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) stage_reg <= '0;
        else      stage_reg <= wptr;
      end
    end else begin : gen_rest
      always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) stage_reg <= '0;
        else      stage_reg <= gen_sync[gi-1].stage_reg;
      end
    end
  end

  assign rq_wptr = gen_sync[SYNC_STAGES-1].stage_reg;

  assign pop        = rinc & ~rempty_reg;
  assign rbin_next  = rbin_reg + {{ADRRSIZE{1'b0}}, pop};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;

  // Empty is evaluated against the post-pop pointer so the last pop raises it at once.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_reg   <= '0;
      rptr_reg   <= '0;
      rempty_reg <= 1'b1;
    end else begin
      rbin_reg   <= rbin_next;
      rptr_reg   <= rgray_next;
      rempty_reg <= (rgray_next == rq_wptr);
    end
  end

  assign raddr  = rbin_reg[ADRRSIZE-1:0];
  assign rptr   = rptr_reg;
  assign rempty = rempty_reg;

`ifdef FIFO_RLEVEL_EN
  logic [ADRRSIZE:0] wbin_s;
  logic [ADRRSIZE:0] rlevel_reg;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= ADRRSIZE; gi++) begin : gen_g2b
    assign wbin_s[gi] = ^rq_wptr[ADRRSIZE:gi];
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) rlevel_reg <= '0;
    else      rlevel_reg <= wbin_s - rbin_next;
  end

  assign rlevel = rlevel_reg;
`endif

endmodule

// File: doc/fifo_rptr_empty.md
Name: fifo_rptr_empty

Overview:
Read-side controller for the dual-clock FIFO. It is the reader counterpart to the FIFO memory's write port.
- Runs entirely in the read clock domain.
- Synchronizes the write-domain Gray pointer and maintains the binary/Gray read pointers.
- Drives the memory read address and generates a registered empty flag.
- Its Gray read pointer is exported for synchronization into the write domain, where it feeds full generation.

Parameters:
ADRRSIZE, 3, memory address width; FIFO depth = 2^ADRRSIZE; pointers are ADRRSIZE+1 bits.
SYNC_STAGES, 2, number of flops in the write-pointer synchronizer chain; legal range 2..4.

Ports:
rclk  input  1  read clock; all state updates on posedge.
rrst  input  1  reset; asynchronous, active-high.
rinc  input  1  read request; pops one entry when rempty=0.
wptr  input  ADRRSIZE+1  Gray-coded write pointer from the write domain (asynchronous to rclk).
raddr  output  ADRRSIZE  read address to the FIFO memory = rbin[ADRRSIZE-1:0].
rptr  output  ADRRSIZE+1  registered Gray-coded read pointer, sent to the write domain.
rempty  output  1  registered empty flag.
rlevel  output  ADRRSIZE+1  occupancy seen by the reader; present only with FIFO_RLEVEL_EN.

Behaviour:
- Clock and reset: one clock (rclk). Reset rrst is asynchronous, active-high.
- Reset values, applied immediately on rrst assertion without waiting for a clock edge:
  - rbin = 0, rptr = 0, raddr = 0
  - all synchronizer flops = 0
  - rempty = 1, rlevel = 0
- Synchronizer:
  - wptr passes through SYNC_STAGES flops; the last stage is rq_wptr.
  - No logic between stages.
  - wptr is never used unsynchronized.
- Pointer update each rclk edge:
  - rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADRRSIZE+1).
  - rgraynext = (rbinnext >> 1) ^ rbinnext.
  - rbin <= rbinnext; rptr <= rgraynext.
- raddr is combinational from the rbin register, so read data is valid in the same cycle rempty=0.
- Empty flag: rempty <= (rgraynext == rq_wptr), a full ADRRSIZE+1 bit compare.
- Pop rule:
  - A pop occurs only when rinc=1 and rempty=0 at the edge.
  - rinc while rempty=1 is ignored: pointers hold and no error is raised.
- Pop of last entry: with rinc=1 and exactly one entry visible, rempty rises on the same edge that advances rptr. No extra cycle.
- Write latency: a wptr change that is stable before edge k is
  - captured by stage 1 at edge k,
  - reaches rq_wptr at edge k+SYNC_STAGES-1,
  - clears rempty at edge k+SYNC_STAGES.
  - For SYNC_STAGES=2, rempty falls after edge k+2.
- Empty is pessimistic: a stale synchronized pointer can hold rempty high longer, never lower early.
- Wrap-around:
  - rbin rolls from 2^(ADRRSIZE+1)-1 to 0.
  - raddr rolls from DEPTH-1 to 0.
  - The MSB distinguishes lap parity; empty requires all bits equal.
- Continuous reads: rinc held high pops one entry per clock while rempty=0. Maximum throughput is 1 word/cycle.
- Mid-operation reset: all outputs return to reset values asynchronously. On rrst release, the first edge evaluates normally from the zero state. The write side must be reset concurrently; this is a system-level requirement, not checked here.

Optional Feature:
- Macro: FIFO_RLEVEL_EN.
- Defined:
  - Port rlevel exists.
  - wbin_s = Gray-to-binary(rq_wptr).
  - rlevel <= (wbin_s - rbinnext) mod 2^(ADRRSIZE+1), registered on the same edge as rempty.
  - rlevel=0 exactly when rempty=1; maximum value is 2^ADRRSIZE.
  - Reset value is 0.
- Not defined: rlevel port and the Gray-to-binary logic are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rrst mid-cycle with wptr=0 → rempty=1, raddr=0, rptr=4'b0000 immediately, before the next rclk edge.
- Single write/read (ADRRSIZE=3, SYNC_STAGES=2): wptr 0000→0001 before edge k → rempty=0 after edge k+2. Then rinc=1 for one cycle → raddr=1, rptr=0001, rempty=1 after that edge.
- Read when empty: rempty=1, rinc held high 5 cycles → raddr and rptr unchanged, rempty stays 1.
- Full lap and wrap: wptr=1100 (Gray 8) synchronized, then rinc held high → raddr 0,1,…,7,0 on successive edges; after the 8th pop rptr=1100 and rempty=1.
- Mid-operation reset: after 5 pops (raddr=5, rptr=0111), pulse rrst between edges → raddr=0, rptr=0000, rempty=1 asynchronously; next pops follow normally after a new wptr arrives.
- FIFO_RLEVEL_EN: wptr=0111 (Gray 5) from reset → rlevel=5 after edge k+2. One pop → rlevel=4. Four more pops → rlevel=0 and rempty=1 on the same edge.
